// File: rtl/mem_access_pkg.sv
// Shared types and lane-mask constants for the mem_access memory stage.
// Optional misalignment trapping is selected by MEM_MISALIGN_CHECK_EN.
package mem_access_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    localparam logic [3:0] BE_W  = 4'b1111;
    localparam logic [3:0] BE_HL = 4'b0011;
    localparam logic [3:0] BE_HH = 4'b1100;
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;

    // Word must sit on addr[1:0]==0, halfword on addr[0]==0; bytes never fault.
    function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] lsb);
        logic r;
        r = 1'b0;
        if (be == BE_W)
            r = (lsb != 2'b00);
        else if (be == BE_HL || be == BE_HH)
            r = lsb[0];
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load aligner: picks the lane(s) named by the byte-enable
// mask out of the read word and sign/zero-extends to 32 bits.
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [3:0]  i_be,
    input  logic        i_sext,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_be)
            BE_W:  o_data = i_rdata;
            BE_HH: o_data = {{16{i_sext & i_rdata[31]}}, i_rdata[31:16]};
            BE_HL: o_data = {{16{i_sext & i_rdata[15]}}, i_rdata[15:0]};
            BE_B3: o_data = {{24{i_sext & i_rdata[31]}}, i_rdata[31:24]};
            BE_B2: o_data = {{24{i_sext & i_rdata[23]}}, i_rdata[23:16]};
            BE_B1: o_data = {{24{i_sext & i_rdata[15]}}, i_rdata[15:8]};
            BE_B0: o_data = {{24{i_sext & i_rdata[7]}},  i_rdata[7:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: single-outstanding req/ack data bus, load alignment and WB forwarding.
// Define MEM_MISALIGN_CHECK_EN to trap misaligned word/half accesses instead of issuing them.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  EX_rd,
    input  logic        EX_rd_vld,
    input  logic [31:0] EX_x_rd,
    input  logic [31:0] EX_MEM_addr,
    input  logic [3:0]  EX_MEM_rden,
    input  logic        EX_MEM_rden_SEXT,
    input  logic [3:0]  EX_MEM_wren,
    input  logic [31:0] EX_MEM_wrdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        MEM_stall,
    output logic [4:0]  MEM_rd,
    output logic        MEM_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic        MEM_misalign_vld,
    output logic [31:0] MEM_misalign_addr
);

    mem_state_t  r_state;
    logic        r_req, r_we, r_sext, r_rd_vld_cap, r_rd_vld, r_mis_vld;
    logic [31:0] r_addr, r_wdata, r_x_rd, r_mis_addr;
    logic [3:0]  r_be;
    logic [4:0]  r_rd_cap, r_rd;
    logic        w_memop, w_we, w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_load_data;

    assign w_memop = (EX_MEM_rden != 4'b0000) || (EX_MEM_wren != 4'b0000);
    assign w_we    = (EX_MEM_rden == 4'b0000);
    assign w_be    = w_we ? EX_MEM_wren : EX_MEM_rden;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = w_memop && is_misaligned(w_be, EX_MEM_addr[1:0]);
`else
    logic w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^EX_MEM_addr[1:0];
    assign w_misalign        = 1'b0;
`endif

    mem_access_load_align u_align (
        .i_rdata (dbus_rdata),
        .i_be    (r_be),
        .i_sext  (r_sext),
        .o_data  (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_sext       <= 1'b0;
            r_rd_cap     <= '0;
            r_rd_vld_cap <= 1'b0;
            r_rd         <= '0;
            r_rd_vld     <= 1'b0;
            r_x_rd       <= '0;
            r_mis_vld    <= 1'b0;
            r_mis_addr   <= '0;
        end else begin
            r_mis_vld <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_misalign) begin
                        r_mis_vld  <= 1'b1;
                        r_mis_addr <= EX_MEM_addr;
                        r_rd_vld   <= 1'b0;
                    end else if (w_memop) begin
                        r_state      <= ST_ACCESS;
                        r_req        <= 1'b1;
                        r_we         <= w_we;
                        r_addr       <= {EX_MEM_addr[31:2], 2'b00};
                        r_be         <= w_be;
                        r_wdata      <= EX_MEM_wrdata;
                        r_sext       <= EX_MEM_rden_SEXT;
                        r_rd_cap     <= EX_rd;
                        r_rd_vld_cap <= EX_rd_vld;
                        r_rd_vld     <= 1'b0;
                    end else begin
                        r_rd     <= EX_rd;
                        r_rd_vld <= EX_rd_vld;
                        r_x_rd   <= EX_x_rd;
                    end
                end
                ST_ACCESS: begin
                    r_rd_vld <= 1'b0;
                    if (dbus_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_x_rd   <= w_load_data;
                            r_rd     <= r_rd_cap;
                            r_rd_vld <= r_rd_vld_cap;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dbus_req          = r_req;
    assign dbus_we           = r_we;
    assign dbus_addr         = r_addr;
    assign dbus_be           = r_be;
    assign dbus_wdata        = r_wdata;
    assign MEM_stall         = (r_state == ST_ACCESS);
    assign MEM_rd            = r_rd;
    assign MEM_rd_vld        = r_rd_vld;
    assign MEM_x_rd          = r_x_rd;
    assign MEM_misalign_vld  = r_mis_vld;
    assign MEM_misalign_addr = r_mis_addr;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; honours MEM_MISALIGN_CHECK_EN.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  EX_rd;
    logic        EX_rd_vld;
    logic [31:0] EX_x_rd, EX_MEM_addr, EX_MEM_wrdata, dbus_rdata;
    logic [3:0]  EX_MEM_rden, EX_MEM_wren;
    logic        EX_MEM_rden_SEXT, dbus_ack;
    logic        dbus_req, dbus_we, MEM_stall, MEM_rd_vld, MEM_misalign_vld;
    logic [31:0] dbus_addr, dbus_wdata, MEM_x_rd, MEM_misalign_addr;
    logic [3:0]  dbus_be;
    logic [4:0]  MEM_rd;

    int vectors = 0;
    int miscompares = 0;
    int stall_cycles;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .EX_rd(EX_rd), .EX_rd_vld(EX_rd_vld), .EX_x_rd(EX_x_rd),
        .EX_MEM_addr(EX_MEM_addr), .EX_MEM_rden(EX_MEM_rden),
        .EX_MEM_rden_SEXT(EX_MEM_rden_SEXT), .EX_MEM_wren(EX_MEM_wren),
        .EX_MEM_wrdata(EX_MEM_wrdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .MEM_stall(MEM_stall), .MEM_rd(MEM_rd), .MEM_rd_vld(MEM_rd_vld),
        .MEM_x_rd(MEM_x_rd), .MEM_misalign_vld(MEM_misalign_vld),
        .MEM_misalign_addr(MEM_misalign_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_nop();
        EX_rd = '0; EX_rd_vld = 1'b0; EX_x_rd = '0; EX_MEM_addr = '0;
        EX_MEM_rden = '0; EX_MEM_wren = '0; EX_MEM_rden_SEXT = 1'b0; EX_MEM_wrdata = '0;
    endtask

    task automatic ex_load(input logic [31:0] a, input logic [3:0] m, input logic s, input logic [4:0] rd);
        ex_nop();
        EX_MEM_addr = a; EX_MEM_rden = m; EX_MEM_rden_SEXT = s; EX_rd = rd; EX_rd_vld = 1'b1;
    endtask

    initial begin
        rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = '0;
        ex_nop();
        step(); step();
        rst = 1'b0;
        chk("rst_req", {31'b0, dbus_req}, 32'd0);
        chk("rst_stall", {31'b0, MEM_stall}, 32'd0);
        chk("rst_rd_vld", {31'b0, MEM_rd_vld}, 32'd0);
        chk("rst_x_rd", MEM_x_rd, 32'd0);
        chk("rst_mis", {31'b0, MEM_misalign_vld}, 32'd0);

        // 1: ALU pass-through
        EX_rd = 5'd5; EX_rd_vld = 1'b1; EX_x_rd = 32'h1234;
        step();
        chk("add_x_rd", MEM_x_rd, 32'h1234);
        chk("add_rd", {27'b0, MEM_rd}, 32'd5);
        chk("add_vld", {31'b0, MEM_rd_vld}, 32'd1);
        chk("add_stall", {31'b0, MEM_stall}, 32'd0);

        // 2: LB, ack on third ACCESS cycle
        ex_load(32'h103, 4'b1000, 1'b1, 5'd7);
        step();
        ex_nop();
        chk("lb_req", {31'b0, dbus_req}, 32'd1);
        chk("lb_addr", dbus_addr, 32'h100);
        chk("lb_be", {28'b0, dbus_be}, 32'h8);
        chk("lb_we", {31'b0, dbus_we}, 32'd0);
        chk("lb_vld_wait", {31'b0, MEM_rd_vld}, 32'd0);
        stall_cycles = 0;
        if (MEM_stall) stall_cycles++;
        step();
        if (MEM_stall) stall_cycles++;
        step();
        if (MEM_stall) stall_cycles++;
        dbus_ack = 1'b1; dbus_rdata = 32'h80123456;
        step();
        dbus_ack = 1'b0;
        chk("lb_stall_cycles", stall_cycles, 32'd3);
        chk("lb_x_rd", MEM_x_rd, 32'hFFFFFF80);
        chk("lb_rd", {27'b0, MEM_rd}, 32'd7);
        chk("lb_vld", {31'b0, MEM_rd_vld}, 32'd1);
        step();
        chk("lb_req_drop", {31'b0, dbus_req}, 32'd0);
        chk("lb_vld_pulse", {31'b0, MEM_rd_vld}, 32'd0);

        // 3: LHU with same-cycle ack -> result after 2 edges
        ex_load(32'h202, 4'b1100, 1'b0, 5'd9);
        step();
        ex_nop();
        chk("lhu_addr", dbus_addr, 32'h200);
        chk("lhu_vld_e1", {31'b0, MEM_rd_vld}, 32'd0);
        dbus_ack = 1'b1; dbus_rdata = 32'hBEEF0000;
        step();
        dbus_ack = 1'b0;
        chk("lhu_x_rd", MEM_x_rd, 32'h0000BEEF);
        chk("lhu_vld_e2", {31'b0, MEM_rd_vld}, 32'd1);
        chk("lhu_rd", {27'b0, MEM_rd}, 32'd9);

        // LBU lane 1 with zero-extension
        ex_load(32'h101, 4'b0010, 1'b0, 5'd10);
        step();
        ex_nop();
        dbus_ack = 1'b1; dbus_rdata = 32'h0000A500;
        step();
        dbus_ack = 1'b0;
        chk("lbu_x_rd", MEM_x_rd, 32'h000000A5);

        // Non-standard mask yields zero data
        ex_load(32'h104, 4'b0110, 1'b1, 5'd11);
        step();
        ex_nop();
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
        step();
        dbus_ack = 1'b0;
        chk("odd_mask_x_rd", MEM_x_rd, 32'h0);
        chk("odd_mask_vld", {31'b0, MEM_rd_vld}, 32'd1);

        // 4: SW, then ADD held during stall retires once
        ex_nop();
        EX_MEM_addr = 32'h40; EX_MEM_wren = 4'b1111; EX_MEM_wrdata = 32'hDEADBEEF;
        step();
        ex_nop();
        EX_rd = 5'd3; EX_rd_vld = 1'b1; EX_x_rd = 32'hAAAA;
        chk("sw_req", {31'b0, dbus_req}, 32'd1);
        chk("sw_we", {31'b0, dbus_we}, 32'd1);
        chk("sw_be", {28'b0, dbus_be}, 32'hF);
        chk("sw_addr", dbus_addr, 32'h40);
        chk("sw_wdata", dbus_wdata, 32'hDEADBEEF);
        step();
        chk("sw_stall", {31'b0, MEM_stall}, 32'd1);
        chk("sw_held_vld", {31'b0, MEM_rd_vld}, 32'd0);
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        chk("sw_ack_vld", {31'b0, MEM_rd_vld}, 32'd0);
        chk("sw_req_drop", {31'b0, dbus_req}, 32'd0);
        step();
        chk("add_after_bubble_vld", {31'b0, MEM_rd_vld}, 32'd1);
        chk("add_after_bubble_x", MEM_x_rd, 32'hAAAA);
        chk("add_after_bubble_rd", {27'b0, MEM_rd}, 32'd3);
        ex_nop();
        step();
        chk("add_once", {31'b0, MEM_rd_vld}, 32'd0);
        chk("sw_no_dup_req", {31'b0, dbus_req}, 32'd0);

        // 5: reset mid-ACCESS, stale ack afterwards
        ex_load(32'h300, 4'b1111, 1'b0, 5'd4);
        step();
        ex_nop();
        chk("rst_mid_req_before", {31'b0, dbus_req}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_req", {31'b0, dbus_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, MEM_stall}, 32'd0);
        dbus_ack = 1'b1; dbus_rdata = 32'h12345678;
        step();
        dbus_ack = 1'b0;
        chk("stale_ack_vld", {31'b0, MEM_rd_vld}, 32'd0);
        chk("stale_ack_x_rd", MEM_x_rd, 32'h0);
        chk("stale_ack_req", {31'b0, dbus_req}, 32'd0);

        // 6: misaligned LW
        ex_load(32'h41, 4'b1111, 1'b0, 5'd6);
        step();
        ex_nop();
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_req", {31'b0, dbus_req}, 32'd0);
        chk("mis_vld", {31'b0, MEM_misalign_vld}, 32'd1);
        chk("mis_addr", MEM_misalign_addr, 32'h41);
        chk("mis_rd_vld", {31'b0, MEM_rd_vld}, 32'd0);
        chk("mis_stall", {31'b0, MEM_stall}, 32'd0);
        step();
        chk("mis_pulse", {31'b0, MEM_misalign_vld}, 32'd0);
`else
        chk("mis_req", {31'b0, dbus_req}, 32'd1);
        chk("mis_addr_bus", dbus_addr, 32'h40);
        chk("mis_be", {28'b0, dbus_be}, 32'hF);
        chk("mis_vld_tied", {31'b0, MEM_misalign_vld}, 32'd0);
        dbus_ack = 1'b1; dbus_rdata = 32'h11223344;
        step();
        dbus_ack = 1'b0;
        chk("mis_lw_x_rd", MEM_x_rd, 32'h11223344);
        chk("mis_addr_tied", MEM_misalign_addr, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
